// File: rtl/mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_lsu                                                       |
// | Purpose  : Load/store adapter between the core data port and a word-only |
// |            bram. Loads become a word read plus lane extract and sign or  |
// |            zero extension. Sub-word stores become read-modify-write      |
// |            because the bram has no byte enables. One transaction at a    |
// |            time.                                                         |
// | Config   : MISALIGN_TRAP_EN - when defined, misaligned half/word         |
// |            requests complete at once with rsp_err=1 and no memory        |
// |            access. When undefined, they are aligned down and proceed.    |
// | Ports    : clk, rst_n (async, active low)                                |
// |            req_valid/req_ready handshake; req_we, req_size,              |
// |            req_unsigned, req_addr, req_wdata request fields              |
// |            rsp_valid (1-cycle pulse), rsp_rdata, rsp_err                 |
// |            mem_rd_en, mem_addr, mem_rd_data, mem_rd_valid, mem_wr_en,    |
// |            mem_wr_data towards the bram                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_lsu #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [1:0]        size_q,      size_d;
    logic              we_q,        we_d;
    logic              uns_q,       uns_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [31:0]       wr_data_q,   wr_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic              req_is_byte;
    logic              req_is_half;
    logic              req_is_word;
    logic [ADDR_W-1:0] req_addr_fixed;
    logic              trap;

    assign req_is_byte = (req_size == SIZE_BYTE);
    assign req_is_half = (req_size == SIZE_HALF);
    assign req_is_word = req_size[1];

    // Offending low bits are dropped so that everything downstream can
    // assume a naturally aligned lane. When trapping is enabled the
    // misaligned requests never leave IDLE, so this is harmless there.
    always_comb begin
        req_addr_fixed = req_addr;
        if (req_is_half) begin
            req_addr_fixed = {req_addr[ADDR_W-1:1], 1'b0};
        end else if (req_is_word) begin
            req_addr_fixed = {req_addr[ADDR_W-1:2], 2'b00};
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    logic rsp_err_q;

    assign misaligned = (req_is_half && req_addr[0]) ||
                        (req_is_word && (req_addr[1:0] != 2'b00));
    assign trap       = misaligned;

    // Error pulse accompanies the immediate trap response only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= (state_q == ST_IDLE) && req_valid && misaligned;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign trap    = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Lane extract and merge on the word coming back from the bram.
    // Addresses are aligned to their access size by the time they are
    // latched, so a byte-granular shift serves byte, half and word alike.
    // ------------------------------------------------------------------
    logic [4:0]  lane_shift;
    logic [31:0] rd_shifted;
    logic [31:0] load_result;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign lane_shift = {addr_q[1:0], 3'b000};
    assign rd_shifted = mem_rd_data >> lane_shift;

    always_comb begin
        load_result = rd_shifted;
        lane_mask   = 32'hFFFF_FFFF;
        if (size_q == SIZE_BYTE) begin
            load_result = uns_q ? {24'h000000, rd_shifted[7:0]}
                                : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            lane_mask   = 32'h0000_00FF << lane_shift;
        end else if (size_q == SIZE_HALF) begin
            load_result = uns_q ? {16'h0000, rd_shifted[15:0]}
                                : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            lane_mask   = 32'h0000_FFFF << lane_shift;
        end
    end

    assign merged = (mem_rd_data & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        wr_data_d   = wr_data_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr_fixed;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (trap) begin
                        // Complete on the next edge without touching memory.
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else if (req_we && req_is_word) begin
                        wr_data_d = req_wdata;
                        state_d   = ST_WR;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d = ST_RD;
                    end
                end
            end

            ST_RD: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (mem_rd_valid) begin
                    if (we_q) begin
                        wr_data_d = merged;
                        state_d   = ST_WR;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = load_result;
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_WR: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'h0;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            size_q      <= 2'b00;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'h0;
            wr_data_q   <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            addr_q      <= addr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            wr_data_q   <= wr_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready   = (state_q == ST_IDLE);
    assign mem_rd_en   = (state_q == ST_RD);
    assign mem_wr_en   = (state_q == ST_WR);
    // Latched address only changes in IDLE, so it is stable RD..WR.
    assign mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wr_data = wr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_lsu                                                    |
// | Purpose  : Self-checking bench for mem_lsu with a word-only bram model   |
// |            (one-cycle read latency) and a scoreboard of expected         |
// |            responses. Honors MISALIGN_TRAP_EN for the misaligned cases.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_lsu;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 1 << (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rd_data;
    logic              mem_rd_valid;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data)
    );

    // ---------------- bram model ----------------
    logic [31:0]       bram [DEPTH];
    logic              pl_en = 1'b0;
    logic [ADDR_W-3:0] pl_idx = '0;
    logic [31:0]       pl_data = 32'h0;

    always @(posedge clk) begin
        if (mem_wr_en) bram[mem_addr[ADDR_W-1:2]] <= mem_wr_data;
        if (pl_en)     bram[pl_idx] <= pl_data;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_valid <= 1'b0;
            mem_rd_data  <= 32'h0;
        end else begin
            mem_rd_valid <= mem_rd_en;
            if (mem_rd_en) mem_rd_data <= bram[mem_addr[ADDR_W-1:2]];
        end
    end

    // ---------------- monitors ----------------
    int edge_cnt = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int rsp_cnt  = 0;
    logic [ADDR_W-1:0] strobe_addrs [$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (mem_rd_en) rd_cnt++;
        if (mem_wr_en) wr_cnt++;
        if (mem_rd_en || mem_wr_en) strobe_addrs.push_back(mem_addr);
        if (rsp_valid) rsp_cnt++;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb [$];

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = idx[ADDR_W-3:0];
        pl_data = data;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Drive one request, wait (bounded) for acceptance, queue its expectation.
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        exp_t e;
        int   n;
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.acc   = edge_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic got, output logic [31:0] rdata,
                            output logic err, output int edge_at);
        got = 1'b0; rdata = 32'h0; err = 1'b0; edge_at = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; rdata = rsp_rdata; err = rsp_err; edge_at = edge_cnt;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0/0", mem_rd_en, mem_wr_en); end
        n_checks++; if (mem_addr !== '0 || mem_wr_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0/0", mem_addr, mem_wr_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got ready=%b rsp=%b want 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_loads();
        logic [1:0]        sz  [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
        logic              un  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [ADDR_W-1:0] ad  [9] = '{13'h13, 13'h13, 13'h10, 13'h11, 13'h12, 13'h12, 13'h10, 13'h10, 13'h10};
        logic [31:0]       ex  [9] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_FFBB, 32'h0000_00AA,
                                       32'hFFFF_8899, 32'h0000_8899, 32'hFFFF_AABB, 32'h8899_AABB,
                                       32'h8899_AABB};
        logic got, err; logic [31:0] rd; int edge_at, rd0, wr0, a0, bad; exp_t e;
        preload(4, 32'h8899_AABB);
        for (int i = 0; i < 9; i++) begin
            rd0 = rd_cnt; wr0 = wr_cnt; a0 = strobe_addrs.size();
            send(1'b0, sz[i], un[i], ad[i], 32'h0, ex[i], 1'b0, 3);
            wait_rsp(got, rd, err, edge_at);
            e = sb.pop_front();
            bad = 0;
            for (int k = a0; k < strobe_addrs.size(); k++) if (strobe_addrs[k] !== 13'h10) bad++;
            n_checks++; if (!got) begin n_fail++; $display("FAIL load%0d_timeout: no rsp_valid", i); end
            n_checks++; if (rd !== e.rdata || err !== e.err) begin
                n_fail++; $display("FAIL load%0d_data: got %h err=%b want %h err=%b", i, rd, err, e.rdata, e.err); end
            n_checks++; if (edge_at - e.acc != e.lat) begin
                n_fail++; $display("FAIL load%0d_latency: got %0d want %0d", i, edge_at - e.acc, e.lat); end
            n_checks++; if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 0 || bad != 0) begin
                n_fail++; $display("FAIL load%0d_strobes: got rd=%0d wr=%0d badaddr=%0d want 1/0/0",
                                   i, rd_cnt - rd0, wr_cnt - wr0, bad); end
        end
    endtask

    task automatic test_sub_store();
        logic [1:0]        sz [3] = '{2'b00, 2'b01, 2'b00};
        logic [ADDR_W-1:0] ad [3] = '{13'h11, 13'h12, 13'h13};
        logic [31:0]       wd [3] = '{32'h0000_00CC, 32'h0000_1234, 32'hFFFF_FF5A};
        logic [31:0]       wx [3] = '{32'h8899_CCBB, 32'h1234_AABB, 32'h5A99_AABB};
        logic got, err; logic [31:0] rd; int edge_at, rd0, wr0, a0, bad; exp_t e;
        for (int i = 0; i < 3; i++) begin
            preload(4, 32'h8899_AABB);
            rd0 = rd_cnt; wr0 = wr_cnt; a0 = strobe_addrs.size();
            send(1'b1, sz[i], 1'b0, ad[i], wd[i], 32'h0, 1'b0, 4);
            wait_rsp(got, rd, err, edge_at);
            e = sb.pop_front();
            bad = 0;
            for (int k = a0; k < strobe_addrs.size(); k++) if (strobe_addrs[k] !== 13'h10) bad++;
            n_checks++; if (!got || rd !== e.rdata || err !== e.err) begin
                n_fail++; $display("FAIL sst%0d_rsp: got v=%b %h err=%b want 1 %h err=%b", i, got, rd, err, e.rdata, e.err); end
            n_checks++; if (edge_at - e.acc != e.lat) begin
                n_fail++; $display("FAIL sst%0d_latency: got %0d want %0d", i, edge_at - e.acc, e.lat); end
            n_checks++; if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 1 || bad != 0) begin
                n_fail++; $display("FAIL sst%0d_strobes: got rd=%0d wr=%0d badaddr=%0d want 1/1/0",
                                   i, rd_cnt - rd0, wr_cnt - wr0, bad); end
            n_checks++; if (bram[4] !== wx[i]) begin
                n_fail++; $display("FAIL sst%0d_mem: got %h want %h", i, bram[4], wx[i]); end
        end
    endtask

    task automatic test_word_store();
        logic got, err; logic [31:0] rd; int edge_at, rd0, wr0, a0; exp_t e;
        preload(5, 32'h0);
        rd0 = rd_cnt; wr0 = wr_cnt; a0 = strobe_addrs.size();
        send(1'b1, 2'b10, 1'b0, 13'h14, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        wait_rsp(got, rd, err, edge_at);
        e = sb.pop_front();
        n_checks++; if (!got || rd !== e.rdata || err !== e.err) begin
            n_fail++; $display("FAIL sw_rsp: got v=%b %h err=%b want 1 %h err=%b", got, rd, err, e.rdata, e.err); end
        n_checks++; if (edge_at - e.acc != e.lat) begin
            n_fail++; $display("FAIL sw_latency: got %0d want %0d", edge_at - e.acc, e.lat); end
        n_checks++; if (rd_cnt - rd0 != 0 || wr_cnt - wr0 != 1 || strobe_addrs[a0] !== 13'h14) begin
            n_fail++; $display("FAIL sw_strobes: got rd=%0d wr=%0d addr=%h want 0/1/014",
                               rd_cnt - rd0, wr_cnt - wr0, strobe_addrs[a0]); end
        n_checks++; if (bram[5] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_mem: got %h want deadbeef", bram[5]); end
    endtask

    task automatic test_misalign();
        logic [1:0]        sz [3] = '{2'b01, 2'b10, 2'b10};
        logic              we [3] = '{1'b0, 1'b0, 1'b1};
        logic [ADDR_W-1:0] ad [3] = '{13'h11, 13'h12, 13'h16};
        logic got, err; logic [31:0] rd; int edge_at, rd0, wr0, ns_exp; exp_t e;
        logic [31:0] ex [3];
        logic [31:0] mem5_exp;
        int          lt [3];
        logic        ee;
`ifdef MISALIGN_TRAP_EN
        ex = '{32'h0, 32'h0, 32'h0};
        lt = '{1, 1, 1};
        ee = 1'b1;
        mem5_exp = 32'h0;
`else
        ex = '{32'hFFFF_AABB, 32'h8899_AABB, 32'h0};
        lt = '{3, 3, 2};
        ee = 1'b0;
        mem5_exp = 32'h5555_AAAA;
`endif
        preload(4, 32'h8899_AABB);
        preload(5, 32'h0);
        for (int i = 0; i < 3; i++) begin
            rd0 = rd_cnt; wr0 = wr_cnt;
            send(we[i], sz[i], 1'b0, ad[i], 32'h5555_AAAA, ex[i], ee, lt[i]);
            wait_rsp(got, rd, err, edge_at);
            e = sb.pop_front();
            ns_exp = (e.lat == 1) ? 0 : 1;
            n_checks++; if (!got || rd !== e.rdata || err !== e.err) begin
                n_fail++; $display("FAIL mis%0d_rsp: got v=%b %h err=%b want 1 %h err=%b", i, got, rd, err, e.rdata, e.err); end
            n_checks++; if (edge_at - e.acc != e.lat) begin
                n_fail++; $display("FAIL mis%0d_latency: got %0d want %0d", i, edge_at - e.acc, e.lat); end
            n_checks++; if ((rd_cnt - rd0) + (wr_cnt - wr0) != ns_exp) begin
                n_fail++; $display("FAIL mis%0d_strobes: got %0d want %0d", i, (rd_cnt - rd0) + (wr_cnt - wr0), ns_exp); end
        end
        n_checks++; if (bram[5] !== mem5_exp) begin
            n_fail++; $display("FAIL mis_mem: got %h want %h", bram[5], mem5_exp); end
    endtask

    task automatic test_reset_mid();
        int wr0, rsp0;
        preload(4, 32'h8899_AABB);
        send(1'b1, 2'b00, 1'b0, 13'h11, 32'h0000_00CC, 32'h0, 1'b0, 4);
        sb.delete();
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        @(negedge clk);           // RD
        @(negedge clk);           // WAIT
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (wr_cnt - wr0 != 0 || rsp_cnt - rsp0 != 0) begin
            n_fail++; $display("FAIL rstmid_activity: got wr=%0d rsp=%0d want 0/0", wr_cnt - wr0, rsp_cnt - rsp0); end
        n_checks++; if (bram[4] !== 32'h8899_AABB) begin
            n_fail++; $display("FAIL rstmid_mem: got %h want 8899aabb", bram[4]); end
        n_checks++; if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003};
        int acc, prev_rsp, n, busy_bad; bit seen; exp_t e;
        for (int i = 0; i < 3; i++) preload(6 + i, words[i]);
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 13'h18;
        req_wdata = 32'h0; req_valid = 1'b1;
        prev_rsp = -1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (req_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b%0d_ready: got %b want 1", i, req_ready); end
            acc = edge_cnt;
            if (i > 0) begin
                n_checks++; if (acc != prev_rsp) begin
                    n_fail++; $display("FAIL b2b%0d_accept_cycle: got %0d want %0d", i, acc, prev_rsp); end
            end
            e.rdata = words[i]; e.err = 1'b0; e.lat = 3; e.acc = acc;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (i < 2) req_addr = req_addr + ADDR_W'(4);
            else       req_valid = 1'b0;
            seen = 1'b0; busy_bad = 0;
            for (n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
                else if (req_ready !== 1'b0) busy_bad++;
            end
            e = sb.pop_front();
            n_checks++; if (!seen || busy_bad != 0) begin
                n_fail++; $display("FAIL b2b%0d_busy: got seen=%b ready_while_busy=%0d want 1/0", i, seen, busy_bad); end
            n_checks++; if (rsp_rdata !== e.rdata || rsp_err !== 1'b0) begin
                n_fail++; $display("FAIL b2b%0d_data: got %h want %h", i, rsp_rdata, e.rdata); end
            n_checks++; if (edge_cnt - e.acc != e.lat) begin
                n_fail++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, edge_cnt - e.acc, e.lat); end
            prev_rsp = edge_cnt;
        end
        n_checks++; if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_final_ready: got %b want 1", req_ready); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sub_store();
        test_word_store();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
